// File: rtl/rgmii_pkg.sv
// rtl/rgmii_pkg.sv - shared RGMII speed encodings, beat type and helpers
package rgmii_pkg;

  localparam logic [1:0] SPEED_10M  = 2'b00;
  localparam logic [1:0] SPEED_100M = 2'b01;
  localparam logic [1:0] SPEED_1G   = 2'b10;

  // One MAC transmit beat as captured on a data-advance strobe
  typedef struct packed {
    logic [7:0] txd;
    logic       en;
    logic       er;
  } gmii_beat_t;

  // Both 2'b10 and 2'b11 select gigabit
  function automatic logic speed_is_1g(input logic [1:0] speed);
    return speed[1];
  endfunction

endpackage

// File: rtl/rgmii_txc_pattern.sv
// rtl/rgmii_txc_pattern.sv - TXC half-cycle pattern from period position
module rgmii_txc_pattern #(
  parameter int CW = 6
) (
  input  logic [CW-1:0] cnt,
  input  logic [CW:0]   period,
  output logic          txc_d1,
  output logic          txc_d2
);

  logic [CW:0] half;

  assign half = period >> 1;

  // High for the first P of the 2P half-cycles; odd P splits inside cnt == P/2
  always_comb begin
    txc_d1 = 1'b0;
    txc_d2 = 1'b0;
    if ({1'b0, cnt} < half) begin
      txc_d1 = 1'b1;
      txc_d2 = 1'b1;
    end else if (period[0] && ({1'b0, cnt} == half)) begin
      txc_d1 = 1'b1;
    end
  end

endmodule

// File: rtl/rgmii_tx_speed_gen.sv
// rtl/rgmii_tx_speed_gen.sv - GMII to RGMII transmit ODDR inputs at 10/100/1000
module rgmii_tx_speed_gen
  import rgmii_pkg::*;
#(
  parameter int    CLK_DIV_100 = 5,
  parameter int    CLK_DIV_10  = 50,
  parameter string BYTE_MODE   = "TRUE"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] speed,
  input  logic [7:0] gmii_txd,
  input  logic       gmii_tx_en,
  input  logic       gmii_tx_er,
  output logic       gmii_tx_clk_en,
  output logic       txc_d1,
  output logic       txc_d2,
  output logic [3:0] td_d1,
  output logic [3:0] td_d2,
  output logic       tx_ctl_d1,
  output logic       tx_ctl_d2,
  output logic [1:0] speed_active,
  output logic       speed_change
);

  // Both dividers must be at least 2 so a slow TXC period always has a low half
  localparam int DIV_MAX = (CLK_DIV_10 > CLK_DIV_100) ? CLK_DIV_10 : CLK_DIV_100;
  localparam int CW      = $clog2(DIV_MAX);
  localparam int PW      = CW + 1;
  localparam bit BYTES   = (BYTE_MODE == "TRUE");

  localparam logic [PW-1:0] P_1G  = PW'(1);
  localparam logic [PW-1:0] P_100 = PW'(CLK_DIV_100);
  localparam logic [PW-1:0] P_10  = PW'(CLK_DIV_10);

  function automatic logic [PW-1:0] period_of(input logic [1:0] spd);
    case (spd)
      SPEED_100M: return P_100;
      SPEED_10M:  return P_10;
      default:    return P_1G;
    endcase
  endfunction

  logic [CW-1:0] cnt, cnt_nxt;
  logic          phase, phase_nxt;
  gmii_beat_t    beat, beat_nxt;
  logic [1:0]    speed_nxt;
  logic [PW-1:0] period, period_nxt;
  logic          at_boundary, speed_load, speed_diff;
  logic          txc1_nxt, txc2_nxt;
  logic [3:0]    nibble, td1_nxt, td2_nxt;
  logic          ctl1_nxt, ctl2_nxt;

  // Period position and MAC advance strobe for the speed currently applied
  always_comb begin
    period         = period_of(speed_active);
    at_boundary    = ({1'b0, cnt} == (period - PW'(1)));
    speed_load     = speed_is_1g(speed_active) || at_boundary;
    speed_diff     = speed_load && (speed != speed_active);
    gmii_tx_clk_en = speed_is_1g(speed_active) || (at_boundary && (!BYTES || phase));
  end

  // Next counter, nibble phase and captured beat; a speed change drops an unfinished byte
  always_comb begin
    speed_nxt = speed_load ? speed : speed_active;
    cnt_nxt   = cnt + CW'(1);
    phase_nxt = phase;
    if (speed_diff) begin
      cnt_nxt   = '0;
      phase_nxt = 1'b0;
    end else if (at_boundary) begin
      cnt_nxt   = '0;
      phase_nxt = BYTES && !speed_is_1g(speed_active) && !phase;
    end
    if (gmii_tx_clk_en) begin
      beat_nxt = {gmii_txd, gmii_tx_en, gmii_tx_er};
    end else if (speed_diff) begin
      beat_nxt = '0;
    end else begin
      beat_nxt = beat;
    end
    period_nxt = period_of(speed_nxt);
  end

  rgmii_txc_pattern #(
    .CW(CW)
  ) u_txc_pattern (
    .cnt    (cnt_nxt),
    .period (period_nxt),
    .txc_d1 (txc1_nxt),
    .txc_d2 (txc2_nxt)
  );

  // ODDR data for the cycle being entered: full byte at 1G, repeated nibble at 10/100
  always_comb begin
    nibble = (BYTES && phase_nxt) ? beat_nxt.txd[7:4] : beat_nxt.txd[3:0];
    if (speed_is_1g(speed_nxt)) begin
      td1_nxt  = beat_nxt.txd[3:0];
      td2_nxt  = beat_nxt.txd[7:4];
      ctl1_nxt = beat_nxt.en;
      ctl2_nxt = beat_nxt.en ^ beat_nxt.er;
    end else begin
      td1_nxt  = nibble;
      td2_nxt  = nibble;
      ctl1_nxt = txc1_nxt ? (beat_nxt.en ^ beat_nxt.er) : beat_nxt.en;
      ctl2_nxt = txc2_nxt ? (beat_nxt.en ^ beat_nxt.er) : beat_nxt.en;
    end
  end

  // Timing state and registered ODDR-side outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      speed_active <= SPEED_1G;
      speed_change <= 1'b0;
      cnt          <= '0;
      phase        <= 1'b0;
      beat         <= '0;
      txc_d1       <= 1'b1;
      txc_d2       <= 1'b0;
      td_d1        <= 4'h0;
      td_d2        <= 4'h0;
      tx_ctl_d1    <= 1'b0;
      tx_ctl_d2    <= 1'b0;
    end else begin
      speed_active <= speed_nxt;
      speed_change <= speed_diff;
      cnt          <= cnt_nxt;
      phase        <= phase_nxt;
      beat         <= beat_nxt;
      txc_d1       <= txc1_nxt;
      txc_d2       <= txc2_nxt;
      td_d1        <= td1_nxt;
      td_d2        <= td2_nxt;
      tx_ctl_d1    <= ctl1_nxt;
      tx_ctl_d2    <= ctl2_nxt;
    end
  end

endmodule

// File: tb/tb_rgmii_tx_speed_gen.sv
// tb/tb_rgmii_tx_speed_gen.sv - scoreboard bench for rgmii_tx_speed_gen
module tb_rgmii_tx_speed_gen;

  typedef struct {
    string       tag;
    logic [15:0] v;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] speed;
  logic [7:0] txd;
  logic       en, er;

  logic       gce_b, txc1_b, txc2_b, ctl1_b, ctl2_b, chg_b;
  logic [3:0] td1_b, td2_b;
  logic [1:0] act_b;
  logic       gce_n, txc1_n, txc2_n, ctl1_n, ctl2_n, chg_n;
  logic [3:0] td1_n, td2_n;
  logic [1:0] act_n;

  logic [15:0] obs_b, obs_n;
  exp_t        q_b[$];
  exp_t        q_n[$];
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  tbl[6];

  always #4 clk = ~clk;

  assign obs_b = {chg_b, act_b, gce_b, txc1_b, txc2_b, ctl1_b, ctl2_b, td1_b, td2_b};
  assign obs_n = {chg_n, act_n, gce_n, txc1_n, txc2_n, ctl1_n, ctl2_n, td1_n, td2_n};

  rgmii_tx_speed_gen #(.CLK_DIV_100(5), .CLK_DIV_10(50), .BYTE_MODE("TRUE")) dut_b (
    .clk(clk), .rst(rst), .speed(speed), .gmii_txd(txd), .gmii_tx_en(en), .gmii_tx_er(er),
    .gmii_tx_clk_en(gce_b), .txc_d1(txc1_b), .txc_d2(txc2_b), .td_d1(td1_b), .td_d2(td2_b),
    .tx_ctl_d1(ctl1_b), .tx_ctl_d2(ctl2_b), .speed_active(act_b), .speed_change(chg_b)
  );

  rgmii_tx_speed_gen #(.CLK_DIV_100(5), .CLK_DIV_10(50), .BYTE_MODE("FALSE")) dut_n (
    .clk(clk), .rst(rst), .speed(speed), .gmii_txd(txd), .gmii_tx_en(en), .gmii_tx_er(er),
    .gmii_tx_clk_en(gce_n), .txc_d1(txc1_n), .txc_d2(txc2_n), .td_d1(td1_n), .td_d2(td2_n),
    .tx_ctl_d1(ctl1_n), .tx_ctl_d2(ctl2_n), .speed_active(act_n), .speed_change(chg_n)
  );

  // Expected vectors for one slow TXC period: TXC high for the first p of 2p half-cycles
  task automatic push_period(input bit to_n, input string tag, input logic [1:0] act,
                             input int p, input int ncyc, input logic [3:0] nib,
                             input logic e, input logic r, input bit ce_last, input bit chg_first);
    exp_t x;
    logic t1, t2, c1, c2, chg, ce;
    for (int c = 0; c < ncyc; c++) begin
      t1  = ((2 * c) < p);
      t2  = ((2 * c + 1) < p);
      c1  = t1 ? (e ^ r) : e;
      c2  = t2 ? (e ^ r) : e;
      chg = chg_first && (c == 0);
      ce  = ce_last && (c == p - 1);
      x.tag = tag;
      x.v   = {chg, act, ce, t1, t2, c1, c2, nib, nib};
      if (to_n) q_n.push_back(x);
      else      q_b.push_back(x);
    end
  endtask

  task automatic push_both(input exp_t x);
    q_b.push_back(x);
    q_n.push_back(x);
  endtask

  task automatic push_rst(input string tag);
    exp_t x;
    x.tag = tag;
    x.v   = {1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0};
    push_both(x);
  endtask

  task automatic push_1g(input logic [7:0] v, input logic e, input logic r);
    exp_t x;
    x.tag = "gig_byte";
    x.v   = {1'b0, 2'b10, 1'b1, 1'b1, 1'b0, e, e ^ r, v[3:0], v[7:4]};
    push_both(x);
  endtask

  task automatic cmp_now();
    exp_t x;
    if (q_b.size() != 0) begin
      x = q_b.pop_front();
      n_cmp++;
      assert (obs_b === x.v) else begin
        n_err++;
        $error("FAIL %s byte_mode observed=%h expected=%h", x.tag, obs_b, x.v);
      end
    end
    if (q_n.size() != 0) begin
      x = q_n.pop_front();
      n_cmp++;
      assert (obs_n === x.v) else begin
        n_err++;
        $error("FAIL %s nibble_mode observed=%h expected=%h", x.tag, obs_n, x.v);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cmp_now();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic drive(input logic [7:0] v, input logic e, input logic r);
    txd = v;
    en  = e;
    er  = r;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{8'h12, 8'h34, 8'hAB, 8'hF0, 8'h0F, 8'hC3};
    rst   = 1'b1;
    speed = 2'b10;
    drive(8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    push_rst("reset_state");
    tick();

    // Gigabit pass-through straight after reset
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i], (i != 5), (i == 3));
      push_1g(tbl[i], (i != 5), (i == 3));
      tick();
    end

    // 100M byte mode: 0xA5, 0x3C with error, idle
    speed = 2'b01;
    drive(8'hA5, 1'b1, 1'b0);
    push_period(1'b0, "m100_a5_lo", 2'b01, 5, 5, 4'h5, 1'b1, 1'b0, 1'b0, 1'b1);
    push_period(1'b0, "m100_a5_hi", 2'b01, 5, 5, 4'hA, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(8'h3C, 1'b1, 1'b1);
    push_period(1'b0, "m100_3c_lo", 2'b01, 5, 5, 4'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    push_period(1'b0, "m100_3c_hi", 2'b01, 5, 5, 4'h3, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(9);
    tick();
    drive(8'h00, 1'b0, 1'b0);
    push_period(1'b0, "m100_idle_lo", 2'b01, 5, 5, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_period(1'b0, "m100_idle_hi", 2'b01, 5, 5, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    ticks(9);

    // Speed glitch that reverts inside one period is ignored
    tick();
    drive(8'h81, 1'b1, 1'b0);
    push_period(1'b0, "m100_81_lo", 2'b01, 5, 5, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    speed = 2'b00;
    tick();
    speed = 2'b01;
    ticks(7);

    // 100M -> 10M requested at cnt=2 truncates 0x81 and takes effect after cnt=4
    tick();
    drive(8'h6E, 1'b1, 1'b1);
    tick();
    tick();
    speed = 2'b00;
    ticks(2);
    push_period(1'b0, "m10_trunc_lo", 2'b00, 50, 50, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    push_period(1'b0, "m10_trunc_hi", 2'b00, 50, 50, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_period(1'b0, "m10_6e_lo",    2'b00, 50, 50, 4'hE, 1'b1, 1'b1, 1'b0, 1'b0);
    push_period(1'b1, "m10_nib_e0",   2'b00, 50, 50, 4'hE, 1'b1, 1'b1, 1'b1, 1'b1);
    push_period(1'b1, "m10_nib_e1",   2'b00, 50, 50, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0);
    push_period(1'b1, "m10_nib_e2",   2'b00, 50, 50, 4'hE, 1'b1, 1'b1, 1'b1, 1'b0);
    ticks(101);
    drive(8'hD2, 1'b1, 1'b0);
    push_period(1'b0, "m10_6e_hi",    2'b00, 50, 50, 4'h6, 1'b1, 1'b1, 1'b1, 1'b0);
    push_period(1'b1, "m10_nib_2",    2'b00, 50, 50, 4'h2, 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(95);

    // Back to 100M, then reset in the middle of the low nibble of 0xD2
    speed = 2'b01;
    ticks(4);
    push_period(1'b0, "m100_d2_lo", 2'b01, 5, 3, 4'h2, 1'b1, 1'b0, 1'b0, 1'b1);
    ticks(3);
    rst = 1'b1;
    drive(8'h4B, 1'b1, 1'b0);
    #1;
    push_rst("reset_async");
    cmp_now();
    push_rst("reset_hold");
    tick();
    rst = 1'b0;
    push_period(1'b0, "post_rst_lo", 2'b01, 5, 5, 4'hB, 1'b1, 1'b0, 1'b0, 1'b1);
    push_period(1'b0, "post_rst_hi", 2'b01, 5, 5, 4'h4, 1'b1, 1'b0, 1'b1, 1'b0);
    ticks(10);

    n_cmp++;
    assert ((q_b.size() == 0) && (q_n.size() == 0)) else begin
      n_err++;
      $error("FAIL scoreboard_drain observed=%0d/%0d expected=0/0", q_b.size(), q_n.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
